sudoku_board_loader: RTL and testbench

Collects per-cell digit results from the handwriting recognizer in any order, buffers a full 9x9 board, then streams it into `Sudoku_Solver` as 81 consecutive `reading`/`data` beats in the solver's column-major cell order. It sits directly upstream of the solver and owns the 11-bit cell encoding the solver consumes: bit 10 = empty, bits 9:0 = one-hot digit.

---
 rtl/sudoku_board_loader_if.sv | 25 ++
 rtl/sudoku_board_loader.sv | 126 ++++++++++++
 tb/tb_sudoku_board_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_board_loader_if.sv
// Recognizer-to-loader cell bus and loader-to-solver stream bus.
// The master side is the recognizer (plus whoever observes the solver stream);
// the slave side is the loader itself.
interface sudoku_board_loader_if;
    logic        cell_valid;
    logic [3:0]  cell_row;
    logic [3:0]  cell_col;
    logic [3:0]  cell_digit;
    logic        cell_ready;
    logic        frame_end;
    logic        reading;
    logic [10:0] data;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output cell_valid, cell_row, cell_col, cell_digit, frame_end,
        input  cell_ready, reading, data, frame_done, frame_err
    );

    modport slave (
        input  cell_valid, cell_row, cell_col, cell_digit, frame_end,
        output cell_ready, reading, data, frame_done, frame_err
    );
endinterface

// File: rtl/sudoku_board_loader.sv
// Buffers a 9x9 board from out-of-order recognizer results, then streams it
// to the solver column-major (row index fastest) as 81 back-to-back beats.
// Cell encoding: bit 10 = empty, bits 9:0 = one-hot digit (bit 0 never used).
module sudoku_board_loader (
    input  logic                  clk,
    input  logic                  rst_n,
    sudoku_board_loader_if.slave  bus
);

    typedef enum logic {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_t;

    localparam logic [10:0] ENC_EMPTY = 11'h400;

    state_t      state_q, state_d;
    logic [3:0]  r_q, c_q;
    logic [3:0]  digit_q [81];
    logic [80:0] filled_q;
    logic        frame_done_q;
    logic        frame_err_q;

    logic        accept;
    logic        cell_legal;
    logic        last_beat;
    logic [6:0]  wr_idx;
    logic [6:0]  rd_idx;

    // Decode the incoming handshake and the current stream position.
    always_comb begin
        accept     = bus.cell_valid && (state_q == COLLECT);
        cell_legal = (bus.cell_row <= 4'd8) && (bus.cell_col <= 4'd8) &&
                     (bus.cell_digit <= 4'd9);
        // Storage is row-major; only meaningful when the cell is legal.
        wr_idx     = {3'b000, bus.cell_row} * 7'd9 + {3'b000, bus.cell_col};
        rd_idx     = {3'b000, r_q} * 7'd9 + {3'b000, c_q};
        last_beat  = (state_q == STREAM) && (r_q == 4'd8) && (c_q == 4'd8);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            // NOTE: flops take non-blocking assignments so every register in
            // the design samples pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic: frame_end starts the stream, the 81st beat ends it.
    always_comb begin
        // NOTE: a default on entry to every combinational block means no path
        // leaves a variable unassigned, so no latch can be inferred.
        state_d = state_q;
        case (state_q)
            COLLECT: if (bus.frame_end) state_d = STREAM;
            STREAM:  if (last_beat)     state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output decode: driven from flops only, no input-to-output paths.
    always_comb begin
        bus.cell_ready = (state_q == COLLECT);
        bus.reading    = (state_q == STREAM);
        bus.data       = ENC_EMPTY;
        if ((state_q == STREAM) && filled_q[rd_idx] && (digit_q[rd_idx] != 4'd0)) begin
            bus.data = 11'd1 << digit_q[rd_idx];
        end
        bus.frame_done = frame_done_q;
        bus.frame_err  = frame_err_q;
    end

    // Stream position: row index runs fastest, wrapping into the column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
            c_q <= 4'd0;
        end else if (state_q == STREAM) begin
            if (r_q == 4'd8) begin
                r_q <= 4'd0;
                c_q <= (c_q == 4'd8) ? 4'd0 : c_q + 4'd1;
            end else begin
                r_q <= r_q + 4'd1;
            end
        end else begin
            r_q <= 4'd0;
            c_q <= 4'd0;
        end
    end

    // Board storage: last legal write wins; the filled mask drops at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the digit array is reset explicitly because the board must
            // read as all-zero after reset; a RAM macro could not do this.
            for (int i = 0; i < 81; i++) begin
                digit_q[i] <= 4'd0;
            end
            filled_q <= '0;
        end else if (last_beat) begin
            filled_q <= '0;
        end else if (accept && cell_legal) begin
            digit_q[wr_idx]  <= bus.cell_digit;
            filled_q[wr_idx] <= 1'b1;
        end
    end

    // Frame status: done pulses after the last beat; err is sticky through it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= last_beat;
            if (accept && !cell_legal) begin
                frame_err_q <= 1'b1;
            end else if (frame_done_q) begin
                frame_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_board_loader.sv
// Self-checking bench for sudoku_board_loader. A board-level model (9x9 array
// of digits plus an error flag) predicts every streamed beat.
module tb_sudoku_board_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sudoku_board_loader_if bus ();

    sudoku_board_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: digit per (row, col); 0 means blank or never written.
    int board [9][9];
    bit model_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_model(input int d);
        if (d == 0) return 32'h400;
        return 32'(2 ** d);
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r][c] = 0;
        model_err = 1'b0;
    endtask

    // One COLLECT cycle: optionally present a cell, optionally pulse frame_end.
    task automatic drive(input bit v, input int row, input int col, input int dig, input bit fe);
        logic [31:0] row_v, col_v, dig_v;
        row_v = row;
        col_v = col;
        dig_v = dig;
        @(negedge clk);
        check("ready_in_collect", bus.cell_ready, 1);
        bus.cell_valid = v;
        bus.cell_row   = row_v[3:0];
        bus.cell_col   = col_v[3:0];
        bus.cell_digit = dig_v[3:0];
        bus.frame_end  = fe;
        @(posedge clk);
        #1;
        bus.cell_valid = 1'b0;
        bus.frame_end  = 1'b0;
        if (v) begin
            if (row > 8 || col > 8 || dig > 9) model_err = 1'b1;
            else board[row][col] = dig;
        end
    endtask

    // Check the 81 beats that follow frame_end, then the frame_done cycle.
    // inject: present cell (8,8,3) during the stream; it must not be stored.
    // abort_at: beat at which reset is asserted (-1 for none).
    task automatic stream(input string name, input bit inject, input int abort_at);
        bit seen_done;
        for (int k = 0; k < 81; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, "_rst_reading"}, bus.reading, 0);
                check({name, "_rst_data"}, bus.data, 32'h400);
                check({name, "_rst_ready"}, bus.cell_ready, 1);
                check({name, "_rst_err"}, bus.frame_err, 0);
                clear_model();
                @(negedge clk);
                rst_n = 1'b1;
                seen_done = 1'b0;
                for (int i = 0; i < 90; i++) begin
                    @(negedge clk);
                    if (bus.frame_done || bus.reading) seen_done = 1'b1;
                end
                check({name, "_no_done_after_rst"}, seen_done, 0);
                return;
            end
            check($sformatf("%s_reading_%0d", name, k), bus.reading, 1);
            check($sformatf("%s_data_%0d", name, k), bus.data, enc_model(board[k % 9][k / 9]));
            check($sformatf("%s_done_low_%0d", name, k), bus.frame_done, 0);
            check($sformatf("%s_err_%0d", name, k), bus.frame_err, model_err);
            if (inject && k == 5) begin
                check({name, "_ready_in_stream"}, bus.cell_ready, 0);
                bus.cell_valid = 1'b1;
                bus.cell_row   = 4'd8;
                bus.cell_col   = 4'd8;
                bus.cell_digit = 4'd3;
                bus.frame_end  = 1'b1;
            end
            if (inject && k == 8) begin
                bus.cell_valid = 1'b0;
                bus.frame_end  = 1'b0;
            end
        end
        @(negedge clk);
        check({name, "_reading_end"}, bus.reading, 0);
        check({name, "_done_pulse"}, bus.frame_done, 1);
        check({name, "_ready_back"}, bus.cell_ready, 1);
        check({name, "_err_at_done"}, bus.frame_err, model_err);
        check({name, "_data_idle"}, bus.data, 32'h400);
        clear_model();
        @(negedge clk);
        check({name, "_done_single"}, bus.frame_done, 0);
        check({name, "_err_cleared"}, bus.frame_err, 0);
        check({name, "_no_restream"}, bus.reading, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cells, row, col, dig;
        bus.cell_valid = 1'b0;
        bus.cell_row   = 4'd0;
        bus.cell_col   = 4'd0;
        bus.cell_digit = 4'd0;
        bus.frame_end  = 1'b0;
        clear_model();

        // Reset state, both while held and after release.
        #12;
        check("rst_ready", bus.cell_ready, 1);
        check("rst_reading", bus.reading, 0);
        check("rst_data", bus.data, 32'h400);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", bus.frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_reading", bus.reading, 0);
        check("post_rst_ready", bus.cell_ready, 1);

        // Basic frame: first beat, second beat, last beat populated.
        drive(1, 0, 0, 5, 0);
        drive(1, 1, 0, 9, 0);
        drive(1, 8, 8, 1, 0);
        drive(0, 0, 0, 0, 1);
        stream("basic", 0, -1);

        // Repeat write: last one wins.
        drive(1, 3, 3, 3, 0);
        drive(1, 3, 3, 7, 0);
        drive(0, 0, 0, 0, 1);
        stream("rewrite", 0, -1);

        // Illegal cells are dropped and flag the frame.
        drive(1, 9, 0, 4, 0);
        drive(1, 2, 2, 12, 0);
        drive(1, 2, 2, 6, 0);
        drive(0, 0, 0, 0, 1);
        stream("illegal", 0, -1);

        // Cell on the frame_end edge is included; cells during stream are not.
        drive(1, 4, 4, 2, 1);
        stream("same_edge", 1, -1);

        // Reset mid-stream discards the frame; next empty frame is all blank.
        drive(1, 6, 1, 8, 0);
        drive(0, 0, 0, 0, 1);
        stream("abort", 0, 30);
        drive(0, 0, 0, 0, 1);
        stream("empty", 0, -1);

        // Randomized frames, occasionally with illegal fields or same-edge cells.
        for (int f = 0; f < 5; f++) begin
            n_cells = $urandom_range(5, 60);
            for (int i = 0; i < n_cells; i++) begin
                row = $urandom_range(0, 8);
                col = $urandom_range(0, 8);
                dig = $urandom_range(0, 9);
                case ($urandom_range(0, 15))
                    0: row = $urandom_range(9, 15);
                    1: col = $urandom_range(9, 15);
                    2: dig = $urandom_range(10, 15);
                    default: ;
                endcase
                drive(1, row, col, dig, (i == n_cells - 1) && f[0]);
            end
            if (!f[0]) drive(0, 0, 0, 0, 1);
            stream($sformatf("rand%0d", f), f == 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
